// File: rtl/iob_fir_decim_pkg.sv
// Shared constants and width helpers for the FIR decimator: default parameter values,
// intermediate width, FIFO depth, rounding constant and saturation limits.
package iob_fir_decim_pkg;

  localparam int DEF_DATA_IN_W   = 16;
  localparam int DEF_DATA_OUT_W  = 8;
  localparam int DEF_SHIFT       = 8;
  localparam int DEF_DECIM_W     = 4;
  localparam int DEF_FIFO_ADDR_W = 2;

  // One guard bit above the input so adding the rounding constant cannot overflow.
  function automatic int mid_width(input int data_in_w);
    return data_in_w + 1;
  endfunction

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Round-half-up: add half an output LSB before the arithmetic shift.
  function automatic int round_const(input int shift);
    return 1 << (shift - 1);
  endfunction

  function automatic int sat_max(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int out_w);
    return -(1 << (out_w - 1));
  endfunction

endpackage

// File: rtl/iob_fir_decim_if.sv
// Sample input, decimated valid/ready output and status bundle of iob_fir_decim.
// master = producer/consumer side, slave = the decimator itself.
interface iob_fir_decim_if #(
  parameter int DATA_IN_W   = 16,
  parameter int DATA_OUT_W  = 8,
  parameter int DECIM_W     = 4,
  parameter int FIFO_ADDR_W = 2
);

  logic                         en;
  logic [DECIM_W-1:0]           decim;
  logic signed [DATA_IN_W-1:0]  data_in;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_OUT_W-1:0] data_out;
  logic [FIFO_ADDR_W:0]         level;
  logic                         drop;
  logic                         drop_clr;

  modport master (
    output en, decim, data_in, out_ready, drop_clr,
    input  out_valid, data_out, level, drop
  );

  modport slave (
    input  en, decim, data_in, out_ready, drop_clr,
    output out_valid, data_out, level, drop
  );

endinterface

// File: rtl/iob_fir_decim_fifo.sv
// Synchronous FIFO with a registered head (rd_data/rd_valid) and occupancy count.
// A word written at edge k becomes visible at the head after edge k+1.
module iob_fir_decim_fifo
  import iob_fir_decim_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   level,
  output logic              full
);

  localparam int DEPTH = fifo_depth(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [ADDR_W:0]   count, count_nxt, avail;
  logic              pop, push_ok;

  always_comb begin
    full       = (count == DEPTH_C);
    pop        = rd_valid & rd_en;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    push_ok    = wr_en & (~full | pop);
    rd_ptr_nxt = rd_ptr + ADDR_W'(pop);
    count_nxt  = count + (ADDR_W + 1)'(push_ok) - (ADDR_W + 1)'(pop);
    // Entries already stored that remain after this cycle's pop; a same-cycle
    // write is not visible at the head until the following edge.
    avail      = count - (ADDR_W + 1)'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      rd_valid <= (avail != '0);
      if (avail != '0) rd_data <= mem[rd_ptr_nxt];
    end
  end

  // NOTE: storage has no reset; count and rd_valid guard every read, so its
  // power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  assign level = count;

endmodule

// File: rtl/iob_fir_decim.sv
// Keep-one-in-N decimator with round/shift/narrow scaling and a buffered valid/ready output.
// Define IOB_FIR_DECIM_SAT_EN to saturate on narrowing; otherwise the result wraps.
module iob_fir_decim
  import iob_fir_decim_pkg::*;
#(
  parameter int DATA_IN_W   = DEF_DATA_IN_W,
  parameter int DATA_OUT_W  = DEF_DATA_OUT_W,
  parameter int SHIFT       = DEF_SHIFT,
  parameter int DECIM_W     = DEF_DECIM_W,
  parameter int FIFO_ADDR_W = DEF_FIFO_ADDR_W
) (
  input logic              clk,
  input logic              rst,
  iob_fir_decim_if.slave   bus
);

  localparam int MID_W = mid_width(DATA_IN_W);
  localparam logic signed [MID_W-1:0] ROUND_C = MID_W'(round_const(SHIFT));

  logic [DECIM_W-1:0]           phase, n_reg, n_cur, decim_eff;
  logic                         started, keep, wrap;
  logic signed [MID_W-1:0]      mid_sum;
  logic signed [DATA_OUT_W-1:0] scaled, s1_data;
  logic                         s1_push, fifo_full, reject;

  // ---------------- phase counter ----------------
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    decim_eff = (bus.decim == '0) ? DECIM_W'(1) : bus.decim;
    // Until the first clock after reset the frame length comes straight from the port.
    n_cur     = started ? n_reg : decim_eff;
    keep      = bus.en && (phase == '0);
    wrap      = bus.en && (phase == n_cur - DECIM_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= '0;
      n_reg   <= DECIM_W'(1);
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (!started) n_reg <= decim_eff;
      if (wrap) begin
        phase <= '0;
        n_reg <= decim_eff;
      end else if (bus.en) begin
        phase <= phase + DECIM_W'(1);
      end
    end
  end

  // ---------------- scaler ----------------
`ifdef IOB_FIR_DECIM_SAT_EN
  localparam logic signed [MID_W-1:0] SAT_MAX = MID_W'(sat_max(DATA_OUT_W));
  localparam logic signed [MID_W-1:0] SAT_MIN = MID_W'(sat_min(DATA_OUT_W));
  logic signed [MID_W-1:0] mid_shift;

  always_comb begin
    mid_sum   = {bus.data_in[DATA_IN_W-1], bus.data_in} + ROUND_C;
    mid_shift = mid_sum >>> SHIFT;
    if (mid_shift > SAT_MAX)      scaled = SAT_MAX[DATA_OUT_W-1:0];
    else if (mid_shift < SAT_MIN) scaled = SAT_MIN[DATA_OUT_W-1:0];
    else                          scaled = mid_shift[DATA_OUT_W-1:0];
  end
`else
  always_comb begin
    mid_sum = {bus.data_in[DATA_IN_W-1], bus.data_in} + ROUND_C;
    scaled  = DATA_OUT_W'(mid_sum >>> SHIFT);
  end
`endif

  // ---------------- stage 1 ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_push <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_push <= keep;
      if (keep) s1_data <= scaled;
    end
  end

  // ---------------- stage 2: output FIFO ----------------
  iob_fir_decim_fifo #(
    .DATA_W (DATA_OUT_W),
    .ADDR_W (FIFO_ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (s1_push),
    .wr_data  (s1_data),
    .rd_en    (bus.out_ready),
    .rd_valid (bus.out_valid),
    .rd_data  (bus.data_out),
    .level    (bus.level),
    .full     (fifo_full)
  );

  // ---------------- drop flag ----------------
  assign reject = s1_push & fifo_full & ~(bus.out_valid & bus.out_ready);

  // A new drop in the same cycle as drop_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.drop <= 1'b0;
    else     bus.drop <= reject | (bus.drop & ~bus.drop_clr);
  end

endmodule

// File: tb/tb_iob_fir_decim.sv
// Directed bench for iob_fir_decim: decimation, rounding, narrowing, backpressure,
// full push/pop, asynchronous reset and mid-frame decimation change.
module tb_iob_fir_decim;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  iob_fir_decim_if #(.DATA_IN_W(16), .DATA_OUT_W(8), .DECIM_W(4), .FIFO_ADDR_W(2)) bus_a ();
  iob_fir_decim_if #(.DATA_IN_W(16), .DATA_OUT_W(8), .DECIM_W(4), .FIFO_ADDR_W(2)) bus_b ();

  iob_fir_decim #(
    .DATA_IN_W(16), .DATA_OUT_W(8), .SHIFT(8), .DECIM_W(4), .FIFO_ADDR_W(2)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  iob_fir_decim #(
    .DATA_IN_W(16), .DATA_OUT_W(8), .SHIFT(4), .DECIM_W(4), .FIFO_ADDR_W(2)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  // The SHIFT=4 instance sees exactly the same stimulus.
  assign bus_b.en        = bus_a.en;
  assign bus_b.decim     = bus_a.decim;
  assign bus_b.data_in   = bus_a.data_in;
  assign bus_b.out_ready = bus_a.out_ready;
  assign bus_b.drop_clr  = bus_a.drop_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input int d);
    check({tag, "_valid"}, 32'(bus_a.out_valid), 32'(v));
    if (v) check({tag, "_data"}, bus_a.data_out, d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst released just after an edge; the next edge is the first after reset exit.
  task automatic do_reset(input int n);
    rst             = 1'b1;
    bus_a.en        = 1'b0;
    bus_a.data_in   = '0;
    bus_a.out_ready = 1'b0;
    bus_a.drop_clr  = 1'b0;
    bus_a.decim     = 4'(n);
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic bit kept_after_change(input int k);
    return (k == 0) || (k >= 4 && (k % 2) == 0);
  endfunction

  logic signed [7:0] sat_hi_exp_b, sat_lo_exp_b, sat_hi_exp_a;

  initial begin
    rst = 1'b0;
    #2;
    do_reset(4);

    // ---- reset values ----
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_data_out",  bus_a.data_out, 0);
    check("rst_level",     32'(bus_a.level), 32'd0);
    check("rst_drop",      32'(bus_a.drop), 32'd0);

    // ---- basic decimation, N=4: keep i=0,4,8,12 -> outputs 0,4,8,12 two edges later ----
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_a.data_in = 16'(i * 256);
      bus_a.en      = 1'b1;
      tick();
      if (i >= 2 && ((i - 2) % 4) == 0) expect_out($sformatf("basic_%0d", i), 1'b1, i - 2);
      else                               expect_out($sformatf("basic_%0d", i), 1'b0, 0);
    end
    bus_a.en = 1'b0;
    tick();
    tick();
    check("basic_drained_level", 32'(bus_a.level), 32'd0);

    // ---- rounding, N=1, back-to-back outputs ----
    do_reset(1);
    bus_a.out_ready = 1'b1;
    begin
      logic [15:0] rin  [4];
      int          rexp [4];
      rin[0] = 16'h0080; rexp[0] = 1;
      rin[1] = 16'h007F; rexp[1] = 0;
      rin[2] = 16'hFF80; rexp[2] = 0;
      rin[3] = 16'hFF7F; rexp[3] = -1;
      for (int j = 0; j < 6; j++) begin
        bus_a.en = (j < 4);
        if (j < 4) bus_a.data_in = rin[j];
        tick();
        if (j >= 2) expect_out($sformatf("round_%0d", j - 2), 1'b1, rexp[j - 2]);
      end
    end
    bus_a.en = 1'b0;

    // ---- saturation / wrap narrowing ----
`ifdef IOB_FIR_DECIM_SAT_EN
    sat_hi_exp_b = 8'sd127;
    sat_lo_exp_b = -8'sd128;
    sat_hi_exp_a = 8'sd127;
`else
    sat_hi_exp_b = 8'sh00;
    sat_lo_exp_b = 8'sh00;
    sat_hi_exp_a = -8'sd128;
`endif
    do_reset(1);
    bus_a.out_ready = 1'b1;
    bus_a.en        = 1'b1;
    bus_a.data_in   = 16'h7FFF;
    tick();
    bus_a.data_in   = 16'h8000;
    tick();
    bus_a.en        = 1'b0;
    tick();
    check("sat_b_hi_valid", 32'(bus_b.out_valid), 32'd1);
    check("sat_b_hi_data",  bus_b.data_out, 32'(sat_hi_exp_b));
    check("sat_a_hi_data",  bus_a.data_out, 32'(sat_hi_exp_a));
    tick();
    check("sat_b_lo_data",  bus_b.data_out, 32'(sat_lo_exp_b));
    check("sat_a_lo_data",  bus_a.data_out, -128);

    // ---- backpressure: 6 samples into a 4-deep FIFO ----
    do_reset(1);
    for (int j = 0; j < 6; j++) begin
      bus_a.en      = 1'b1;
      bus_a.data_in = 16'((j + 1) * 256);
      tick();
    end
    bus_a.en = 1'b0;
    tick();
    tick();
    check("bp_level", 32'(bus_a.level), 32'd4);
    check("bp_drop",  32'(bus_a.drop), 32'd1);
    tick();
    check("bp_drop_sticky", 32'(bus_a.drop), 32'd1);
    bus_a.drop_clr = 1'b1;
    tick();
    bus_a.drop_clr = 1'b0;
    check("bp_drop_clr", 32'(bus_a.drop), 32'd0);
    check("bp_level_kept", 32'(bus_a.level), 32'd4);
    bus_a.out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      expect_out($sformatf("bp_pop_%0d", m), 1'b1, m + 1);
      tick();
    end
    expect_out("bp_empty", 1'b0, 0);
    check("bp_empty_level", 32'(bus_a.level), 32'd0);

    // ---- full FIFO with simultaneous push and pop ----
    do_reset(1);
    for (int j = 0; j < 10; j++) begin
      bus_a.en        = 1'b1;
      bus_a.data_in   = 16'((j + 1) * 256);
      bus_a.out_ready = (j >= 5);
      tick();
      if (j == 4) begin
        check("full_level_pre", 32'(bus_a.level), 32'd4);
        expect_out("full_head_pre", 1'b1, 1);
      end
      if (j >= 5) begin
        check($sformatf("full_level_%0d", j), 32'(bus_a.level), 32'd4);
        check($sformatf("full_drop_%0d", j),  32'(bus_a.drop), 32'd0);
        expect_out($sformatf("full_head_%0d", j), 1'b1, j - 3);
      end
    end
    bus_a.en = 1'b0;

    // ---- asynchronous reset mid-stream ----
    do_reset(1);
    for (int j = 0; j < 3; j++) begin
      bus_a.en      = 1'b1;
      bus_a.data_in = 16'((j + 1) * 256);
      tick();
    end
    bus_a.en = 1'b0;
    tick();
    tick();
    check("mrst_level_pre", 32'(bus_a.level), 32'd3);
    check("mrst_valid_pre", 32'(bus_a.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mrst_valid", 32'(bus_a.out_valid), 32'd0);
    check("mrst_level", 32'(bus_a.level), 32'd0);

    // ---- decim changes 4 -> 2 mid-frame; new N applies from the next frame ----
    do_reset(4);
    bus_a.out_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      bus_a.en      = 1'b1;
      bus_a.data_in = 16'(j * 256);
      if (j == 2) bus_a.decim = 4'd2;
      tick();
      if (j >= 2 && kept_after_change(j - 2)) expect_out($sformatf("dchg_%0d", j), 1'b1, j - 2);
      else                                     expect_out($sformatf("dchg_%0d", j), 1'b0, 0);
    end
    bus_a.en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
